// File: rtl/dmem_bridge.sv
// Data-memory bridge between the MEM stage and a request/grant bus.
// It holds the pipeline until the access completes, errors or times out.
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [29:0] addr_to_mem,
  input  logic [3:0]  be,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        start;
  logic        expired;

  assign start   = req_valid && (be != 4'b0000);
  assign expired = (cnt_q == TimeoutLast);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          we_d    = req_we;
          addr_d  = addr_to_mem;
          be_d    = be;
          wdata_d = data_to_mem;
          cnt_d   = 16'd0;
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_gnt) begin
          if (bus_err) begin
            err_d   = 1'b1;
            state_d = StDone;
            if (!we_q) rdata_d = 32'd0;
          end else if (we_q) begin
            state_d = StDone;
          end else if (bus_rvalid) begin
            rdata_d = bus_rdata;
            state_d = StDone;
          end else if (expired) begin
            // A grant alone is not a completion, so the timeout still wins.
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_err) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = StDone;
        end else if (bus_rvalid) begin
          rdata_d = bus_rdata;
          state_d = StDone;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= 30'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus_req       = (state_q == StReq);
    bus_we        = bus_req && we_q;
    bus_addr      = bus_req ? addr_q : 30'd0;
    bus_be        = bus_req ? be_q : 4'd0;
    bus_wdata     = bus_req ? wdata_q : 32'd0;
    done          = (state_q == StDone);
    err           = done && err_q;
    data_from_mem = rdata_q;
    stall         = !rst && (((state_q == StIdle) && start) ||
                             (state_q == StReq) || (state_q == StWait));
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Scenario bench for dmem_bridge: done pulses are scored against a queue of
// expected {err, data_from_mem}; a second instance with TIMEOUT=4 covers timeouts.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid_t = 1'b0;
  logic        req_we = 1'b0;
  logic [29:0] addr_to_mem = '0;
  logic [3:0]  be = '0;
  logic [31:0] data_to_mem = '0;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  logic [31:0] data_from_mem, bus_wdata;
  logic        stall, done, err, bus_req, bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;

  logic [31:0] data_t, bus_wdata_t;
  logic        stall_t, done_t, err_t, bus_req_t, bus_we_t;
  logic [29:0] bus_addr_t;
  logic [3:0]  bus_be_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];
  logic [31:0] exp_data = 32'd0;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .addr_to_mem(addr_to_mem), .be(be), .data_to_mem(data_to_mem),
    .data_from_mem(data_from_mem), .stall(stall), .done(done), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  dmem_bridge #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .req_valid(req_valid_t), .req_we(req_we),
    .addr_to_mem(addr_to_mem), .be(be), .data_to_mem(data_to_mem),
    .data_from_mem(data_t), .stall(stall_t), .done(done_t), .err(err_t),
    .bus_req(bus_req_t), .bus_we(bus_we_t), .bus_addr(bus_addr_t), .bus_be(bus_be_t),
    .bus_wdata(bus_wdata_t), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  // Scoreboard: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done got err=%b data=%h want no done", err, data_from_mem);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({err, data_from_mem} !== e) begin
          n_fail++;
          $display("FAIL sb_done got err=%b data=%h want err=%b data=%h",
                   err, data_from_mem, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; be = 4'hf;
    step(); step();
    settle();
    n_tests++;
    if ({stall, done, err, bus_req} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 0000", {stall, done, err, bus_req});
    end
    n_tests++;
    if (data_from_mem !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0", data_from_mem);
    end
    rst = 1'b0; req_valid = 1'b0; be = 4'h0;
    exp_data = 32'd0;
    step();
  endtask

  task automatic test_load_fast();
    req_valid = 1'b1; req_we = 1'b0; be = 4'hf; addr_to_mem = 30'h100;
    exp_q.push_back({1'b0, 32'hCAFE_F00D});
    exp_data = 32'hCAFE_F00D;
    settle();
    n_tests++;
    if ({stall, bus_req} !== 2'b10) begin
      n_fail++; $display("FAIL ldfast_c1 got %b want 10", {stall, bus_req});
    end
    step();
    req_valid = 1'b0; bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    settle();
    n_tests++;
    if ({stall, bus_req, bus_we, bus_addr} !== {3'b110, 30'h100}) begin
      n_fail++; $display("FAIL ldfast_c2 got %b/%h want 110/100", {stall, bus_req, bus_we}, bus_addr);
    end
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    settle();
    n_tests++;
    if ({done, err, stall} !== 3'b100 || data_from_mem !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL ldfast_c3 got %b/%h want 100/cafef00d", {done, err, stall}, data_from_mem);
    end
    step();
  endtask

  task automatic test_store();
    req_valid = 1'b1; req_we = 1'b1; be = 4'b0011;
    addr_to_mem = 30'(32'h0000_0010 >> 2); data_to_mem = 32'h1234_1234; bus_gnt = 1'b1;
    exp_q.push_back({1'b0, exp_data});
    settle();
    n_tests++;
    if ({stall, bus_req} !== 2'b10) begin
      n_fail++; $display("FAIL store_c1 got %b want 10", {stall, bus_req});
    end
    step();
    req_valid = 1'b0; data_to_mem = 32'hFFFF_FFFF; be = 4'hf;
    settle();
    n_tests++;
    if ({stall, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !==
        {3'b111, 30'h4, 4'b0011, 32'h1234_1234}) begin
      n_fail++;
      $display("FAIL store_bus got %b a=%h be=%b d=%h want 111 a=4 be=0011 d=12341234",
               {stall, bus_req, bus_we}, bus_addr, bus_be, bus_wdata);
    end
    step();
    settle();
    n_tests++;
    if ({done, err, stall, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !==
        {4'b1000, 1'b0, 30'd0, 4'd0, 32'd0} || data_from_mem !== exp_data) begin
      n_fail++;
      $display("FAIL store_done got %b a=%h d=%h mem=%h want 1000 zeros mem=%h",
               {done, err, stall, bus_req}, bus_addr, bus_wdata, data_from_mem, exp_data);
    end
    bus_gnt = 1'b0;
    step();
    settle();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL store_pulse got done=%b want 0", done);
    end
  endtask

  task automatic test_load_wait();
    req_valid = 1'b1; req_we = 1'b0; be = 4'hf; addr_to_mem = 30'h2A;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    exp_data = 32'hDEAD_BEEF;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // Responses without a grant must be ignored.
      bus_rvalid = (i == 0); bus_err = (i == 1); bus_rdata = 32'h0BAD_0BAD;
      settle();
      n_tests++;
      if ({stall, bus_req, done} !== 3'b110) begin
        n_fail++; $display("FAIL ldwait_req%0d got %b want 110", i, {stall, bus_req, done});
      end
      step();
    end
    bus_rvalid = 1'b0; bus_err = 1'b0; bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    settle();
    n_tests++;
    if ({stall, bus_req, done} !== 3'b100) begin
      n_fail++; $display("FAIL ldwait_w1 got %b want 100", {stall, bus_req, done});
    end
    step();
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    settle();
    n_tests++;
    if ({stall, done} !== 2'b10) begin
      n_fail++; $display("FAIL ldwait_w2 got %b want 10", {stall, done});
    end
    step();
    bus_rvalid = 1'b0;
    settle();
    n_tests++;
    if ({done, err, stall} !== 3'b100 || data_from_mem !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ldwait_done got %b/%h want 100/deadbeef", {done, err, stall}, data_from_mem);
    end
    step();
  endtask

  task automatic test_load_err();
    req_valid = 1'b1; req_we = 1'b0; be = 4'hf; addr_to_mem = 30'h3;
    exp_q.push_back({1'b1, 32'd0});
    exp_data = 32'd0;
    step();
    req_valid = 1'b0; bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0; bus_err = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
    step();
    bus_err = 1'b0; bus_rvalid = 1'b0;
    settle();
    n_tests++;
    if ({done, err} !== 2'b11 || data_from_mem !== 32'd0) begin
      n_fail++; $display("FAIL ldErr_done got %b/%h want 11/00000000", {done, err}, data_from_mem);
    end
    step();
    settle();
    n_tests++;
    if ({done, err} !== 2'b00) begin
      n_fail++; $display("FAIL ldErr_after got %b want 00", {done, err});
    end
  endtask

  task automatic test_timeout();
    req_valid_t = 1'b1; req_we = 1'b0; be = 4'hf; addr_to_mem = 30'h7;
    settle();
    n_tests++;
    if (stall_t !== 1'b1) begin
      n_fail++; $display("FAIL to_c1 got stall=%b want 1", stall_t);
    end
    step();
    req_valid_t = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_tests++;
      if ({bus_req_t, done_t, stall_t} !== 3'b101) begin
        n_fail++; $display("FAIL to_req%0d got %b want 101", i, {bus_req_t, done_t, stall_t});
      end
      step();
    end
    settle();
    n_tests++;
    if ({done_t, err_t, bus_req_t, stall_t} !== 4'b1100) begin
      n_fail++; $display("FAIL to_done got %b want 1100", {done_t, err_t, bus_req_t, stall_t});
    end
    step();
    settle();
    n_tests++;
    if ({done_t, err_t} !== 2'b00) begin
      n_fail++; $display("FAIL to_after got %b want 00", {done_t, err_t});
    end
  endtask

  task automatic test_reset_in_wait();
    req_valid = 1'b1; req_we = 1'b0; be = 4'hf; addr_to_mem = 30'h9;
    step();
    req_valid = 1'b0; bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0; rst = 1'b1; req_valid = 1'b1;
    settle();
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_stall got %b want 0", stall);
    end
    step();
    rst = 1'b0; req_valid = 1'b0; exp_data = 32'd0;
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_tests++;
      if ({stall, done, bus_req} !== 3'b000 || data_from_mem !== exp_data) begin
        n_fail++; $display("FAIL rstwait_idle%0d got %b/%h want 000/%h",
                           i, {stall, done, bus_req}, data_from_mem, exp_data);
      end
      step();
    end
    bus_rvalid = 1'b0;
  endtask

  task automatic test_be_zero();
    req_valid = 1'b1; req_we = 1'b1; be = 4'b0000; bus_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_tests++;
      if ({stall, bus_req, done} !== 3'b000) begin
        n_fail++; $display("FAIL be0_c%0d got %b want 000", i, {stall, bus_req, done});
      end
      step();
    end
    req_valid = 1'b0; bus_gnt = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] want_stall;
    logic [5:0] want_req;
    logic [5:0] want_done;
    want_stall = 6'b011011;  // bit i = cycle i
    want_req   = 6'b010010;
    want_done  = 6'b100100;
    req_valid = 1'b1; req_we = 1'b1; be = 4'b1100; addr_to_mem = 30'h55;
    data_to_mem = 32'hA5A5_A5A5; bus_gnt = 1'b1;
    exp_q.push_back({1'b0, exp_data});
    exp_q.push_back({1'b0, exp_data});
    for (int i = 0; i < 6; i++) begin
      if (i == 4) req_valid = 1'b0;
      settle();
      n_tests++;
      if ({stall, bus_req, done} !== {want_stall[i], want_req[i], want_done[i]}) begin
        n_fail++; $display("FAIL b2b_c%0d got %b want %b", i, {stall, bus_req, done},
                           {want_stall[i], want_req[i], want_done[i]});
      end
      step();
    end
    bus_gnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_fast();
    test_store();
    test_load_wait();
    test_load_err();
    test_timeout();
    test_reset_in_wait();
    test_be_zero();
    test_back_to_back();
    step(); step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
